// File: rtl/spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arb
// Description : Round-robin arbiter in front of a single SPI master (mode 0,
//               MSB first). A granted requester's slave index and TX frame
//               are captured at grant. The frame is then shifted out while
//               MISO is shifted in. A request that targets IDLE_SS completes
//               immediately with err set and no bus activity.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arb #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int SS_W    = 2,
  parameter int CLK_DIV = 2,
  parameter int IDLE_SS = 2**SS_W-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*SS_W-1:0]      req_slave,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           grant,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic                       err,
  output logic [WIDTH-1:0]           rx_data,
  output logic                       busy,
  output logic                       SCLK,
  output logic                       MOSI,
  input  logic                       MISO,
  output logic [SS_W-1:0]            SS
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2*WIDTH) + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST       = DIV_W'(CLK_DIV-1);
  localparam logic [HALF_W-1:0] HALF_LAST      = HALF_W'(2*WIDTH-1);
  localparam logic [HALF_W-1:0] HALF_LAST_FALL = HALF_W'(2*WIDTH-2);
  localparam logic [SS_W-1:0]   IDLE_SS_V      = SS_W'(IDLE_SS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              sclk_q, sclk_d;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              err_q, err_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic [SS_W-1:0]   win_slave;
  logic [WIDTH-1:0]  win_data;
  logic [N_REQ-1:0]  grant_c;
  logic              div_end;

  // Round-robin search: first requester at or after last_grant+1 (mod N_REQ)
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_slave = req_slave[win_idx*SS_W +: SS_W];
  assign win_data  = req_data[win_idx*WIDTH +: WIDTH];
  assign div_end   = (div_q == DIV_LAST);

  // Next-state and datapath updates; every register holds unless changed below
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    half_d       = half_q;
    sclk_d       = sclk_q;
    ss_d         = ss_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rx_data_d    = rx_data_q;
    done_id_d    = done_id_q;
    err_d        = err_q;
    grant_c      = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_c      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          last_grant_d = win_idx;
          id_d         = win_idx;
          div_d        = '0;
          if (win_slave == IDLE_SS_V) begin
            // Rejected: report straight away, bus stays untouched
            state_d   = DONE;
            err_d     = 1'b1;
            done_id_d = win_idx;
            rx_data_d = rx_q;
          end else begin
            // MOSI is tx_q's MSB, so loading the frame presents bit WIDTH-1
            state_d = SETUP;
            ss_d    = win_slave;
            tx_d    = win_data;
            sclk_d  = 1'b0;
          end
        end
      end

      SETUP: begin
        if (div_end) begin
          // Leaving SETUP is the first rising SCLK edge
          state_d = SHIFT;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[WIDTH-2:0], MISO};
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            state_d = HOLD;
            sclk_d  = 1'b0;
          end else begin
            half_d = half_q + 1'b1;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rx_d = {rx_q[WIDTH-2:0], MISO};
            end else if (half_q != HALF_LAST_FALL) begin
              // Falling edge: advance to next TX bit (not after the last bit)
              tx_d = {tx_q[WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      HOLD: begin
        if (div_end) begin
          state_d   = DONE;
          ss_d      = IDLE_SS_V;
          tx_d      = '0;
          done_id_d = id_q;
          rx_data_d = rx_q;
          err_d     = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      half_q       <= '0;
      sclk_q       <= 1'b0;
      ss_q         <= IDLE_SS_V;
      tx_q         <= '0;
      rx_q         <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(N_REQ-1);
      rx_data_q    <= '0;
      done_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      half_q       <= half_d;
      sclk_q       <= sclk_d;
      ss_q         <= ss_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rx_data_q    <= rx_data_d;
      done_id_q    <= done_id_d;
      err_q        <= err_d;
    end
  end

  assign grant   = rst ? '0 : grant_c;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign done_id = done_id_q;
  assign err     = err_q;
  assign rx_data = rx_data_q;
  assign SCLK    = sclk_q;
  assign MOSI    = tx_q[WIDTH-1];
  assign SS      = ss_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arb
// Description : Scoreboard bench for spi_master_arb (default build plus a
//               WIDTH=4 / CLK_DIV=1 build) with an SPI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- default build ----------------
  logic [3:0]  req = '0;
  logic [7:0]  req_slave = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic        done, err, busy, sclk, mosi;
  logic        miso = 1'b0;
  logic [1:0]  done_id, ss;
  logic [7:0]  rx_data;

  spi_master_arb #(.WIDTH(8), .N_REQ(4), .SS_W(2), .CLK_DIV(2), .IDLE_SS(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_slave(req_slave), .req_data(req_data),
    .grant(grant), .done(done), .done_id(done_id), .err(err), .rx_data(rx_data),
    .busy(busy), .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS(ss)
  );

  // ---------------- small build ----------------
  logic [3:0]  s_req = '0;
  logic [7:0]  s_slave = '0;
  logic [15:0] s_data = '0;
  logic [3:0]  s_grant;
  logic        s_done, s_err, s_busy, s_sclk, s_mosi;
  logic        s_miso = 1'b0;
  logic [1:0]  s_done_id, s_ss;
  logic [3:0]  s_rx;

  spi_master_arb #(.WIDTH(4), .N_REQ(4), .SS_W(2), .CLK_DIV(1), .IDLE_SS(3)) dut_small (
    .clk(clk), .rst(rst), .req(s_req), .req_slave(s_slave), .req_data(s_data),
    .grant(s_grant), .done(s_done), .done_id(s_done_id), .err(s_err), .rx_data(s_rx),
    .busy(s_busy), .SCLK(s_sclk), .MOSI(s_mosi), .MISO(s_miso), .SS(s_ss)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req_v, cyc);
  endtask

  // Frame each slave answers with
  function automatic logic [7:0] pat_of(input logic [1:0] s);
    case (s)
      2'd0:    pat_of = 8'hC3;
      2'd1:    pat_of = 8'h81;
      2'd2:    pat_of = 8'h3C;
      default: pat_of = 8'h00;
    endcase
  endfunction

  typedef struct {
    logic [3:0] grant;
    int         gap;
    logic [1:0] id;
    logic       err;
    logic [7:0] rx;
    logic [7:0] tx;
    logic [1:0] slave;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   inflight = 1'b0;
  int   grant_cyc = 0;
  int   last_done_cyc = -100;

  always @(posedge clk) cyc++;

  // ---------------- slave model (default build) ----------------
  int         rise_cnt = 0;
  int         sel_cnt  = 0;
  logic [7:0] mosi_cap = '0;
  logic [1:0] seen_ss  = 2'd3;
  logic [7:0] shreg    = '0;
  logic       prev_sclk = 1'b0;
  logic [1:0] prev_ss   = 2'd3;

  always @(negedge clk) begin
    if (grant != 4'd0) begin
      rise_cnt = 0;
      sel_cnt  = 0;
      mosi_cap = '0;
      seen_ss  = 2'd3;
    end else begin
      if (ss != 2'd3) begin
        sel_cnt++;
        seen_ss = ss;
      end
      if (sclk && !prev_sclk) begin
        rise_cnt++;
        mosi_cap = {mosi_cap[6:0], mosi};
      end
      if (ss != 2'd3 && prev_ss == 2'd3) begin
        shreg = pat_of(ss);
        miso  = shreg[7];
      end else if (!sclk && prev_sclk) begin
        shreg = {shreg[6:0], 1'b0};
        miso  = shreg[7];
      end
    end
    prev_sclk = sclk;
    prev_ss   = ss;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (grant != 4'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", grant, 4'd0);
      end else begin
        cur = exp_q.pop_front();
        check("grant", grant, cur.grant);
        if (cur.gap >= 0) check("done_to_grant_gap", cyc - last_done_cyc, cur.gap);
        grant_cyc = cyc;
        inflight  = 1'b1;
      end
    end
    if (done) begin
      if (!inflight) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        check("done_id", done_id, cur.id);
        check("err", err, cur.err);
        check("latency", cyc - grant_cyc, cur.lat);
        check("done_ss_idle", ss, 2'd3);
        check("done_mosi_low", mosi, 1'b0);
        if (cur.err) begin
          check("err_sclk_rises", rise_cnt, 0);
          check("err_ss_cycles", sel_cnt, 0);
        end else begin
          check("rx_data", rx_data, cur.rx);
          check("mosi_stream", mosi_cap, cur.tx);
          check("ss_value", seen_ss, cur.slave);
          check("sclk_rises", rise_cnt, 8);
          check("ss_cycles", sel_cnt, 36);
        end
        inflight      = 1'b0;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input int gap, input logic [1:0] id,
                      input logic [1:0] sl, input logic [7:0] tx);
    exp_t e;
    e.grant = g;
    e.gap   = gap;
    e.id    = id;
    e.slave = sl;
    e.tx    = tx;
    e.err   = (sl == 2'd3);
    e.rx    = pat_of(sl);
    e.lat   = e.err ? 1 : 37;
    exp_q.push_back(e);
  endtask

  // Wait for every queued grant, drop requests, then wait for the last done
  task automatic finish_xfers();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 400) begin tick(); b++; end
    if (exp_q.size() != 0) begin
      check("grant_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    req = '0;
    b = 0;
    while (inflight && b < 100) begin tick(); b++; end
    if (inflight) begin
      check("done_timeout", inflight, 1'b0);
      inflight = 1'b0;
    end
    tick();
  endtask

  // ---------------- small build: WIDTH=4, CLK_DIV=1 ----------------
  int         s_rise = 0;
  int         s_r1 = 0, s_r2 = 0;
  logic [3:0] s_cap = '0;
  logic [3:0] s_sh = '0;
  logic       s_prev_sclk = 1'b0;
  logic [1:0] s_prev_ss = 2'd3;
  bit         small_done = 1'b0;

  always @(negedge clk) begin
    if (s_grant != 4'd0) begin
      s_rise = 0;
      s_cap  = '0;
    end else begin
      if (s_sclk && !s_prev_sclk) begin
        s_rise++;
        s_cap = {s_cap[2:0], s_mosi};
        if (s_rise == 1) s_r1 = cyc;
        if (s_rise == 2) s_r2 = cyc;
      end
      if (s_ss != 2'd3 && s_prev_ss == 2'd3) begin
        s_sh   = 4'b1001;
        s_miso = s_sh[3];
      end else if (!s_sclk && s_prev_sclk) begin
        s_sh   = {s_sh[2:0], 1'b0};
        s_miso = s_sh[3];
      end
    end
    s_prev_sclk = s_sclk;
    s_prev_ss   = s_ss;
  end

  initial begin : small_test
    int b;
    int g;
    wait (rst == 1'b0);
    tick();
    s_slave = 8'b00_00_00_01;
    s_data  = 16'h000A;
    s_req   = 4'b0001;
    @(negedge clk);
    check("s_grant", s_grant, 4'b0001);
    g = cyc;
    tick();
    s_req = '0;
    b = 0;
    while (!s_done && b < 30) begin @(negedge clk); b++; end
    check("s_done_seen", s_done, 1'b1);
    check("s_latency", cyc - g, 11);
    check("s_rx_data", s_rx, 4'b1001);
    check("s_mosi_stream", s_cap, 4'hA);
    check("s_sclk_rises", s_rise, 4);
    check("s_sclk_period", s_r2 - s_r1, 2);
    small_done = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  initial begin : driver
    int b;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss", ss, 2'd3);
    check("rst_grant", grant, 4'd0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_done_id", done_id, 2'd0);
    tick();
    rst = 1'b0;

    // All four requesters held: 0,1,2,3 then 0 again, back to back
    push(4'b0001, -1, 2'd0, 2'd0, 8'h11);
    push(4'b0010,  1, 2'd1, 2'd1, 8'h22);
    push(4'b0100,  1, 2'd2, 2'd2, 8'h33);
    push(4'b1000,  1, 2'd3, 2'd1, 8'h44);
    push(4'b0001,  1, 2'd0, 2'd0, 8'h11);
    req_slave = {2'd1, 2'd2, 2'd1, 2'd0};
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req       = 4'b1111;
    finish_xfers();

    // Single request, slave 2 answers 3C
    push(4'b0010, -1, 2'd1, 2'd2, 8'hA5);
    req_slave[3:2] = 2'd2;
    req_data[15:8] = 8'hA5;
    req = 4'b0010;
    finish_xfers();
    repeat (3) tick();
    @(negedge clk);
    check("hold_rx_data", rx_data, 8'h3C);
    check("hold_done_id", done_id, 2'd1);

    // Request to IDLE_SS is rejected
    tick();
    push(4'b1000, -1, 2'd3, 2'd3, 8'h00);
    req_slave[7:6] = 2'd3;
    req = 4'b1000;
    finish_xfers();

    // Reset after the third rising SCLK edge aborts the transfer
    push(4'b0100, -1, 2'd2, 2'd2, 8'h96);
    req_slave[5:4]  = 2'd2;
    req_data[23:16] = 8'h96;
    req = 4'b0100;
    b = 0;
    while (!(exp_q.size() == 0 && rise_cnt == 3) && b < 100) begin tick(); b++; end
    check("abort_third_rise_seen", rise_cnt, 3);
    req      = '0;
    rst      = 1'b1;
    inflight = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_sclk", sclk, 1'b0);
    check("abort_ss", ss, 2'd3);
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (60) tick();

    // Inputs changed right after grant; req[2] pulsed while busy is ignored
    push(4'b0001, -1, 2'd0, 2'd0, 8'hF0);
    req_slave[1:0] = 2'd0;
    req_data[7:0]  = 8'hF0;
    req = 4'b0001;
    b = 0;
    while (exp_q.size() != 0 && b < 20) begin tick(); b++; end
    req_data[7:0]  = 8'h0F;
    req_slave[1:0] = 2'd1;
    req = 4'b0100;
    repeat (5) tick();
    req = '0;
    finish_xfers();

    b = 0;
    while (!small_done && b < 100) begin tick(); b++; end
    if (!small_done) check("small_timeout", small_done, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
